// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the x^8+x^4+x^3+x^2+1 Fibonacci PRBS.
// Self-synchronises to the incoming stream, flags mismatches once locked and
// keeps a saturating 8-bit error count shown on two seven-segment digits.
// Optional build macro: PRBS_CHK_SEG_EN adds the hex-to-segment decoders;
// without it both digits are held blank (8'hFF).
module prbs_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       clr_err,
    output logic       locked,
    output logic       bit_err,
    output logic [7:0] err_cnt,
    output logic [7:0] seg0,
    output logic [7:0] seg1
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    // Error counter increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef PRBS_CHK_SEG_EN
    // Active-low segments, bit0=a .. bit6=g, bit7=dp (kept off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sr;
    logic [7:0] w_sr_nxt;
    logic [2:0] r_fill_cnt;
    logic [2:0] w_fill_nxt;
    logic [7:0] r_match_cnt;
    logic [7:0] w_match_nxt;
    logic [7:0] r_miss_cnt;
    logic [7:0] w_miss_nxt;
    logic [7:0] r_err_cnt;
    logic [7:0] w_err_nxt;
    logic       w_err_hit;
    logic       r_locked;
    logic       r_bit_err;
    logic       w_pred;

    // Next bit predicted from the last eight: newest bit enters at r_sr[7].
    assign w_pred = r_sr[4] ^ r_sr[3] ^ r_sr[2] ^ r_sr[0];

    // State register: FILL -> SEARCH -> LOCKED, LOCKED falls back to SEARCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, predictor shift and counter updates for one valid bit.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_fill_nxt  = r_fill_cnt;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_hit   = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_FILL: begin
                    w_sr_nxt   = {din, r_sr[7:1]};
                    w_fill_nxt = r_fill_cnt + 3'd1;
                    if (r_fill_cnt == 3'd7) begin
                        w_state_nxt = ST_SEARCH;
                        w_match_nxt = 8'd0;
                    end
                end
                ST_SEARCH: begin
                    w_sr_nxt = {din, r_sr[7:1]};
                    // An all-zero register predicts zeros forever; never trust it.
                    if ((din == w_pred) && (r_sr != 8'd0)) begin
                        w_match_nxt = r_match_cnt + 8'd1;
                        if (r_match_cnt + 8'd1 == LOCK_TGT) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = 8'd0;
                            w_miss_nxt  = 8'd0;
                        end
                    end else begin
                        w_match_nxt = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so a corrupted bit cannot poison it.
                    w_sr_nxt = {w_pred, r_sr[7:1]};
                    if (din != w_pred) begin
                        w_err_hit  = 1'b1;
                        w_miss_nxt = r_miss_cnt + 8'd1;
                        if (r_miss_cnt + 8'd1 == LOSS_TGT) begin
                            w_state_nxt = ST_SEARCH;
                            w_match_nxt = 8'd0;
                            w_miss_nxt  = 8'd0;
                            w_sr_nxt    = {din, r_sr[7:1]};
                        end
                    end else begin
                        w_miss_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end
    end

    // Error count: a clear request overrides a coincident error.
    always_comb begin
        w_err_nxt = r_err_cnt;
        if (clr_err) begin
            w_err_nxt = 8'd0;
        end else if (w_err_hit) begin
            w_err_nxt = sat_inc8(r_err_cnt);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= 8'd0;
            r_fill_cnt  <= 3'd0;
            r_match_cnt <= 8'd0;
            r_miss_cnt  <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_locked    <= 1'b0;
            r_bit_err   <= 1'b0;
        end else begin
            r_sr        <= w_sr_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err_cnt   <= w_err_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_bit_err   <= w_err_hit;
        end
    end

    assign locked  = r_locked;
    assign bit_err = r_bit_err;
    assign err_cnt = r_err_cnt;

`ifdef PRBS_CHK_SEG_EN
    logic [7:0] r_seg0;
    logic [7:0] r_seg1;

    // Digits follow the next error count so they change with err_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg0 <= 8'hC0;
            r_seg1 <= 8'hC0;
        end else begin
            r_seg0 <= hex_to_seg(w_err_nxt[3:0]);
            r_seg1 <= hex_to_seg(w_err_nxt[7:4]);
        end
    end

    assign seg0 = r_seg0;
    assign seg1 = r_seg1;
`else
    assign seg0 = 8'hFF;
    assign seg1 = 8'hFF;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed burst table, hand sequences for lock timing,
// saturation and reset, and a randomized run against a reference model.
module tb_prbs_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       bit_err;
    logic [7:0] err_cnt;
    logic [7:0] seg0;
    logic [7:0] seg1;

    prbs_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
        .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt), .seg0(seg0), .seg1(seg1)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Expected digit pattern for a hex nibble, or blank when digits are disabled.
    function automatic logic [7:0] exp_seg(input int v);
`ifdef PRBS_CHK_SEG_EN
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[v & 15];
`else
        return (v >= 0) ? 8'hFF : 8'hFF;
`endif
    endfunction

    // ---------------- stream generator (seed 8'h01, LSB first) ----------------
    bit gq[$];
    task automatic gen_reset();
        gq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endtask
    task automatic gen_next(output bit b);
        b = gq[0];
        gq.push_back(gq[4] ^ gq[3] ^ gq[2] ^ gq[0]);
        void'(gq.pop_front());
    endtask

    // ---------------- reference model ----------------
    bit mq[$];           // last eight bits the checker believes, oldest first
    bit m_filled, m_locked, m_bit_err;
    int m_seen, m_run, m_miss, m_err;

    task automatic model_reset();
        mq.delete();
        m_filled = 0; m_locked = 0; m_bit_err = 0;
        m_seen = 0; m_run = 0; m_miss = 0; m_err = 0;
    endtask
    task automatic model_push(input bit b);
        mq.push_back(b);
        if (mq.size() > 8) void'(mq.pop_front());
    endtask
    task automatic model_step(input bit d, input bit v, input bit c);
        bit pred;
        int ones;
        bit hit;
        hit = 0;
        if (v) begin
            if (!m_filled) begin
                model_push(d);
                m_seen++;
                if (m_seen == 8) begin m_filled = 1; m_run = 0; end
            end else begin
                pred = mq[4] ^ mq[3] ^ mq[2] ^ mq[0];
                ones = 0;
                foreach (mq[i]) ones += int'(mq[i]);
                if (!m_locked) begin
                    if (d == pred && ones != 0) m_run++; else m_run = 0;
                    model_push(d);
                    if (m_run == LOCK_N) begin m_locked = 1; m_miss = 0; end
                end else if (d != pred) begin
                    hit = 1;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_locked = 0; m_run = 0; model_push(d);
                    end else begin
                        model_push(pred);
                    end
                end else begin
                    m_miss = 0;
                    model_push(pred);
                end
            end
        end
        if (c) m_err = 0;
        else if (hit) m_err = (m_err >= 255) ? 255 : m_err + 1;
        m_bit_err = hit;
    endtask

    task automatic check_model();
        chk("locked", {7'd0, locked}, {7'd0, m_locked});
        chk("bit_err", {7'd0, bit_err}, {7'd0, m_bit_err});
        chk("err_cnt", err_cnt, 8'(m_err));
        chk("seg0", seg0, exp_seg(m_err % 16));
        chk("seg1", seg1, exp_seg(m_err / 16));
    endtask

    // One clock of stimulus; outputs checked 1 time unit after the edge.
    task automatic step(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clr_err = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        check_model();
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        gen_next(b);
        step(b ^ flip, 1'b1, c);
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        din_valid = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_err", err_cnt, 8'd0);
        chk("rst_biterr", {7'd0, bit_err}, 8'd0);
        chk("rst_seg0", seg0, exp_seg(0));
        chk("rst_seg1", seg1, exp_seg(0));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        gen_reset();
    endtask

    typedef struct {
        int   flips;
        int   clean;
        bit   clr;
        logic [7:0] exp_err;
        logic exp_locked;
    } burst_t;

    burst_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lock_at;
        int vcnt;
        bit seen_lock;
        bit b;
        bit v;

        tbl[0] = '{1, 10, 1'b0, 8'd1,  1'b1};
        tbl[1] = '{4,  5, 1'b0, 8'd5,  1'b0};
        tbl[2] = '{0, 30, 1'b0, 8'd5,  1'b1};
        tbl[3] = '{2,  3, 1'b0, 8'd7,  1'b1};
        tbl[4] = '{3,  1, 1'b0, 8'd10, 1'b1};
        tbl[5] = '{1,  2, 1'b1, 8'd0,  1'b1};
        tbl[6] = '{4, 30, 1'b0, 8'd4,  1'b1};

        model_reset();
        gen_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Clean stream: lock on exactly the 24th valid bit.
        lock_at = 0;
        for (int i = 1; i <= 40; i++) begin
            send(1'b0, 1'b0);
            if (locked && lock_at == 0) lock_at = i;
        end
        chk("lock_point", 8'(lock_at), 8'(8 + LOCK_N));

        // Directed error bursts.
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < tbl[k].flips; j++)
                send(1'b1, tbl[k].clr && (j == tbl[k].flips - 1));
            for (int j = 0; j < tbl[k].clean; j++) send(1'b0, 1'b0);
            chk("tbl_err", err_cnt, tbl[k].exp_err);
            chk("tbl_locked", {7'd0, locked}, {7'd0, tbl[k].exp_locked});
        end

        // Long clean run: no errors accumulate.
        for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
        chk("clean_err", err_cnt, 8'd4);

        // Saturation with relock between bursts.
        for (int k = 0; k < 75; k++) begin
            for (int j = 0; j < 4; j++) send(1'b1, 1'b0);
            for (int j = 0; j < 30; j++) send(1'b0, 1'b0);
        end
        chk("sat_err", err_cnt, 8'hFF);
        chk("sat_seg0", seg0, exp_seg(15));
        chk("sat_seg1", seg1, exp_seg(15));
        send(1'b1, 1'b1);
        chk("clr_vs_err", err_cnt, 8'h00);
        chk("clr_biterr", {7'd0, bit_err}, 8'd1);

        // All-zero stream never locks.
        do_reset();
        seen_lock = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked) seen_lock = 1;
        end
        chk("zero_lock", {7'd0, seen_lock}, 8'd0);
        chk("zero_err", err_cnt, 8'd0);

        // Gapped valid: lock point counted in valid bits only.
        do_reset();
        lock_at = 0;
        vcnt = 0;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin gen_next(b); vcnt++; end
            else b = 1'($urandom_range(0, 1));
            step(b, v, 1'b0);
            if (locked && lock_at == 0) lock_at = vcnt;
        end
        chk("gap_lock_point", 8'(lock_at), 8'(8 + LOCK_N));

        // Reset while locked with a nonzero count.
        send(1'b1, 1'b0);
        chk("pre_rst_err", err_cnt, 8'd1);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                gen_next(b);
                b = b ^ ($urandom_range(0, 19) == 0);
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(b, v, ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
